// File: rtl/hog_axil_pkg.sv
// Shared types and helpers for the HOG GP AXI4-Lite register file.
package hog_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Byte-lane merge sized for the widest supported bus; callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    for (int b = 0; b < 8; b++)
      merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/axil_gp_regfile_if.sv
// AXI4-Lite bus bundle for the GP control port; master drives requests, slave drives responses.
interface axil_gp_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [2:0]          s_axi_awprot;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [2:0]          s_axi_arprot;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
           s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axil_wr_capture.sv
// Independent AW/W holding registers; both = address and data held. Zero latency to hold,
// each channel stalls while its slot is full or a write response is outstanding.
module axil_wr_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                busy,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb,
  output logic                both
);
  logic aw_held;
  logic w_held;

  assign awready = en && !aw_held && !busy;
  assign wready  = en && !w_held && !busy;
  assign both    = aw_held && w_held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr    <= '0;
      data    <= '0;
      strb    <= '0;
    end else begin
      if (clear) begin
        aw_held <= 1'b0;
      end else if (awvalid && awready) begin
        aw_held <= 1'b1;
        addr    <= awaddr;
      end
      if (clear) begin
        w_held <= 1'b0;
      end else if (wvalid && wready) begin
        w_held <= 1'b1;
        data   <= wdata;
        strb   <= wstrb;
      end
    end
  end
endmodule

// File: rtl/axil_gp_regfile.sv
// AXI4-Lite register file for the HOG GP port: R/W config words, RO status words and a start pulse.
// Writes commit one edge after AW and W are both held; reads register on the AR handshake.
import hog_axil_pkg::*;

module axil_gp_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 8,
  parameter int NUM_RW   = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  axil_gp_regfile_if.slave                    bus,
  output logic [NUM_RW*DATA_W-1:0]            regs_o,
  input  logic [(NUM_REGS-NUM_RW)*DATA_W-1:0] status_i,
  output logic                                start_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  logic              rdy_en;
  logic [DATA_W-1:0] regs [NUM_RW];

  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [STRB_W-1:0] cap_strb;
  logic              both;
  logic              commit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_hit;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_new;
  logic [63:0]       merge_full;
  wr_state_t         wr_state;
  wr_state_t         wr_next;

  logic [IDX_W-1:0]  r_idx;
  logic              r_hit;
  logic              ar_fire;
  logic [DATA_W-1:0] rd_word;
  rd_state_t         rd_state;
  rd_state_t         rd_next;

  // Holds every ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  axil_wr_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy_en),
    .busy    (bus.s_axi_bvalid),
    .clear   (commit),
    .awaddr  (bus.s_axi_awaddr),
    .awvalid (bus.s_axi_awvalid),
    .awready (bus.s_axi_awready),
    .wdata   (bus.s_axi_wdata),
    .wstrb   (bus.s_axi_wstrb),
    .wvalid  (bus.s_axi_wvalid),
    .wready  (bus.s_axi_wready),
    .addr    (cap_addr),
    .data    (cap_data),
    .strb    (cap_strb),
    .both    (both)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_state <= W_IDLE;
    else      wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: if (both) wr_next = W_RESP;
      W_RESP: if (bus.s_axi_bready) wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    bus.s_axi_bvalid = (wr_state == W_RESP);
    commit           = (wr_state == W_IDLE) && both;
  end

  assign w_idx = cap_addr[ADDR_W-1:LSB];

  always_comb begin
    w_hit  = 1'b0;
    wr_old = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (int'(w_idx) == i) begin
        w_hit  = 1'b1;
        wr_old = regs[i];
      end
    end
  end

  assign merge_full = strb_merge(64'(wr_old), 64'(cap_data), 8'(cap_strb));

  // Bit 0 of word 0 is the start trigger and never stores.
  always_comb begin
    wr_new = merge_full[DATA_W-1:0];
    if (w_idx == '0) wr_new[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
      bus.s_axi_bresp <= RESP_OKAY;
      start_o         <= 1'b0;
    end else begin
      start_o <= commit && w_hit && (w_idx == '0) && cap_strb[0] && cap_data[0];
      if (commit) begin
        bus.s_axi_bresp <= w_hit ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++)
          if (w_hit && int'(w_idx) == i) regs[i] <= wr_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_state <= R_IDLE;
    else      rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: if (ar_fire) rd_next = R_DATA;
      R_DATA: if (bus.s_axi_rready) rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.s_axi_arready = rdy_en && (rd_state == R_IDLE);
    bus.s_axi_rvalid  = (rd_state == R_DATA);
    ar_fire           = bus.s_axi_arvalid && rdy_en && (rd_state == R_IDLE);
  end

  assign r_idx = bus.s_axi_araddr[ADDR_W-1:LSB];

  always_comb begin
    r_hit   = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (int'(r_idx) == i) begin
        r_hit   = 1'b1;
        rd_word = regs[i];
      end
    end
    for (int i = 0; i < NUM_REGS - NUM_RW; i++) begin
      if (int'(r_idx) == NUM_RW + i) begin
        r_hit   = 1'b1;
        rd_word = status_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read data is captured once per AR so it stays stable under later writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.s_axi_rdata <= '0;
      bus.s_axi_rresp <= RESP_OKAY;
    end else if (ar_fire) begin
      bus.s_axi_rdata <= rd_word;
      bus.s_axi_rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

  wire unused_ok = ^{bus.s_axi_awprot, bus.s_axi_arprot, cap_addr[LSB-1:0],
                     bus.s_axi_araddr[LSB-1:0], merge_full};
endmodule

// File: tb/tb_axil_gp_regfile.sv
// Scoreboard bench for axil_gp_regfile: directed AXI-Lite traffic with queued expected B/R responses.
module tb_axil_gp_regfile;
  import hog_axil_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [191:0] regs0, regs1;
  logic [63:0]  status;
  logic         start0, start1;

  axil_gp_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  axil_gp_regfile_if #(.DATA_W(32), .ADDR_W(6)) bus1 ();

  axil_gp_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(8), .NUM_RW(6)) dut0 (
    .clk(clk), .rst(rst_n), .bus(bus0.slave), .regs_o(regs0), .status_i(status), .start_o(start0));
  axil_gp_regfile #(.DATA_W(32), .ADDR_W(6), .NUM_REGS(8), .NUM_RW(6)) dut1 (
    .clk(clk), .rst(rst_n), .bus(bus1.slave), .regs_o(regs1), .status_i(status), .start_o(start1));

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t      rq0[$];
  rexp_t      rq1[$];
  logic [1:0] bq0[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: handshake or response did not arrive", nm);
  endtask

  // Monitors: pop one expectation per completed response handshake.
  always @(negedge clk) begin
    rexp_t e;
    if (rst_n && bus0.s_axi_rvalid && bus0.s_axi_rready) begin
      if (rq0.size() == 0) flag("r0_unexpected");
      else begin
        e = rq0.pop_front();
        chk("r0_data", 192'(bus0.s_axi_rdata), 192'(e.data));
        chk("r0_resp", 192'(bus0.s_axi_rresp), 192'(e.resp));
      end
    end
  end

  always @(negedge clk) begin
    rexp_t e;
    if (rst_n && bus1.s_axi_rvalid && bus1.s_axi_rready) begin
      if (rq1.size() == 0) flag("r1_unexpected");
      else begin
        e = rq1.pop_front();
        chk("r1_data", 192'(bus1.s_axi_rdata), 192'(e.data));
        chk("r1_resp", 192'(bus1.s_axi_rresp), 192'(e.resp));
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && bus0.s_axi_bvalid && bus0.s_axi_bready) begin
      if (bq0.size() == 0) flag("b0_unexpected");
      else begin
        e = bq0.pop_front();
        chk("b0_resp", 192'(bus0.s_axi_bresp), 192'(e));
      end
    end
  end

  task automatic aw_send(input logic [4:0] a);
    bus0.s_axi_awaddr  = a;
    bus0.s_axi_awvalid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus0.s_axi_awready) break;
      if (n == 50) begin flag("aw_timeout"); break; end
    end
    @(posedge clk); #1;
    bus0.s_axi_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    bus0.s_axi_wdata  = d;
    bus0.s_axi_wstrb  = s;
    bus0.s_axi_wvalid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus0.s_axi_wready) break;
      if (n == 50) begin flag("w_timeout"); break; end
    end
    @(posedge clk); #1;
    bus0.s_axi_wvalid = 1'b0;
  endtask

  task automatic ar_send0(input logic [4:0] a);
    bus0.s_axi_araddr  = a;
    bus0.s_axi_arvalid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus0.s_axi_arready) break;
      if (n == 50) begin flag("ar0_timeout"); break; end
    end
    @(posedge clk); #1;
    bus0.s_axi_arvalid = 1'b0;
  endtask

  task automatic rd1(input logic [5:0] a, input logic [31:0] d, input logic [1:0] r);
    rq1.push_back({d, r});
    bus1.s_axi_araddr  = a;
    bus1.s_axi_arvalid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus1.s_axi_arready) break;
      if (n == 50) begin flag("ar1_timeout"); break; end
    end
    @(posedge clk); #1;
    bus1.s_axi_arvalid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    bq0.push_back(r);
    fork
      aw_send(a);
      w_send(d, s);
    join
  endtask

  task automatic rd0(input logic [4:0] a, input logic [31:0] d, input logic [1:0] r);
    rq0.push_back({d, r});
    ar_send0(a);
  endtask

  task automatic drain();
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (rq0.size() == 0 && rq1.size() == 0 && bq0.size() == 0) break;
      if (n == 60) begin flag("drain_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    status = {32'hA5A5A5A5, 32'h11112222};
    bus0.s_axi_awaddr = '0; bus0.s_axi_awprot = '0; bus0.s_axi_awvalid = 1'b0;
    bus0.s_axi_wdata  = '0; bus0.s_axi_wstrb  = '0; bus0.s_axi_wvalid  = 1'b0;
    bus0.s_axi_araddr = '0; bus0.s_axi_arprot = '0; bus0.s_axi_arvalid = 1'b0;
    bus0.s_axi_bready = 1'b1; bus0.s_axi_rready = 1'b1;
    bus1.s_axi_awaddr = '0; bus1.s_axi_awprot = '0; bus1.s_axi_awvalid = 1'b0;
    bus1.s_axi_wdata  = '0; bus1.s_axi_wstrb  = '0; bus1.s_axi_wvalid  = 1'b0;
    bus1.s_axi_araddr = '0; bus1.s_axi_arprot = '0; bus1.s_axi_arvalid = 1'b0;
    bus1.s_axi_bready = 1'b1; bus1.s_axi_rready = 1'b1;

    // Reset dropped in the middle of a write whose AW is already held.
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    aw_send(5'h08);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 192'(bus0.s_axi_awready), 192'(0));
    chk("rst_wready",  192'(bus0.s_axi_wready),  192'(0));
    chk("rst_arready", 192'(bus0.s_axi_arready), 192'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_awready", 192'(bus0.s_axi_awready), 192'(1));
    chk("post_wready",  192'(bus0.s_axi_wready),  192'(1));
    chk("post_arready", 192'(bus0.s_axi_arready), 192'(1));
    chk("post_bvalid",  192'(bus0.s_axi_bvalid),  192'(0));
    chk("post_rvalid",  192'(bus0.s_axi_rvalid),  192'(0));
    chk("post_regs",    regs0,                    192'(0));
    chk("post_start",   192'(start0),             192'(0));

    // AW three cycles ahead of W, partial strobes.
    aw_send(5'h04);
    repeat (2) @(posedge clk);
    #1;
    bq0.push_back(RESP_OKAY);
    w_send(32'hDEADBEEF, 4'b0011);
    chk("b_before_commit", 192'(bus0.s_axi_bvalid), 192'(0));
    @(posedge clk); #1;
    chk("b_at_commit", 192'(bus0.s_axi_bvalid), 192'(1));
    chk("reg1_beef",   192'(regs0[63:32]),      192'(32'h0000BEEF));
    rd0(5'h04, 32'h0000BEEF, RESP_OKAY);

    wr(5'h08, 32'h12345678, 4'b1100, RESP_OKAY);
    wr(5'h04, 32'hFFFFFFFF, 4'b0000, RESP_OKAY);
    rd0(5'h08, 32'h12340000, RESP_OKAY);
    rd0(5'h04, 32'h0000BEEF, RESP_OKAY);

    // RO write rejected; status words readable; low address bits ignored.
    wr(5'h18, 32'hFFFFFFFF, 4'b1111, RESP_SLVERR);
    drain();
    chk("regs_after_ro", regs0, {32'h0, 32'h0, 32'h0, 32'h12340000, 32'h0000BEEF, 32'h0});
    rd0(5'h1C, 32'hA5A5A5A5, RESP_OKAY);
    rd0(5'h18, 32'h11112222, RESP_OKAY);
    rd0(5'h1F, 32'hA5A5A5A5, RESP_OKAY);

    // Wider address space: index 8 is out of range.
    rd1(6'h20, 32'h0, RESP_SLVERR);
    rd1(6'h1C, 32'hA5A5A5A5, RESP_OKAY);

    // Start pulse and self-clearing bit 0.
    drain();
    wr(5'h00, 32'h00000003, 4'b1111, RESP_OKAY);
    chk("start_pre", 192'(start0), 192'(0));
    @(posedge clk); #1;
    chk("start_hi", 192'(start0), 192'(1));
    @(posedge clk); #1;
    chk("start_lo",  192'(start0),       192'(0));
    chk("reg0_regs", 192'(regs0[31:0]),  192'(32'h2));
    rd0(5'h00, 32'h00000002, RESP_OKAY);
    drain();
    wr(5'h00, 32'h00000001, 4'b1110, RESP_OKAY);
    @(posedge clk); #1;
    chk("no_start_strb", 192'(start0), 192'(0));
    rd0(5'h00, 32'h00000002, RESP_OKAY);

    // Read stalled by rready while a same-index write commits on the AR edge.
    wr(5'h0C, 32'h0000AAAA, 4'b1111, RESP_OKAY);
    drain();
    bus0.s_axi_rready = 1'b0;
    bq0.push_back(RESP_OKAY);
    rq0.push_back({32'h0000AAAA, RESP_OKAY});
    fork
      begin
        fork
          aw_send(5'h0C);
          w_send(32'h55555555, 4'b1111);
        join
      end
      begin
        @(posedge clk); #1;
        ar_send0(5'h0C);
      end
      begin
        repeat (14) begin
          @(posedge clk); #1;
          bus0.s_axi_bready = 1'($urandom_range(0, 1));
        end
        bus0.s_axi_bready = 1'b1;
      end
    join
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_rvalid",  192'(bus0.s_axi_rvalid),  192'(1));
      chk("stall_rdata",   192'(bus0.s_axi_rdata),   192'(32'h0000AAAA));
      chk("stall_arready", 192'(bus0.s_axi_arready), 192'(0));
    end
    chk("reg3_new", 192'(regs0[127:96]), 192'(32'h55555555));
    bus0.s_axi_rready = 1'b1;
    drain();
    rd0(5'h0C, 32'h55555555, RESP_OKAY);

    drain();
    chk("dut1_regs",  regs1,          192'(0));
    chk("dut1_start", 192'(start1),   192'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
